chip8_sprite_drawer: RTL and testbench

Sequencer for the CHIP-8 DXYN instruction. It sits between the CPU execute stage and the framebuffer/display block. On a start pulse it fetches N sprite bytes from memory starting at I and issues one single-cycle `draw` per row to the display stage. It ORs the per-row collision flags returned by the display into a VF result, then pulses `done`.

---
 rtl/chip8_sprite_drawer.sv | 153 +++++++++++++++
 tb/tb_chip8_sprite_drawer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_drawer.sv
// chip8_sprite_drawer: sequencer for the CHIP-8 DXYN instruction.
// Fetches N sprite rows from memory and strobes one draw per row.
//
// Ports:
//   clk, reset        : clock; async active-high reset
//   start             : DXYN request, sampled only when idle
//   vx, vy, n, i_reg  : x origin, y origin, rows, sprite base address
//   mem_addr, mem_rd  : sprite byte read (data returns next cycle)
//   mem_data          : sprite byte from memory
//   draw, x, y,
//   row_index,
//   sprite_data       : one-cycle row draw request to the display stage
//   collision         : registered per-row collision, valid after draw
//   busy, done, vf    : status, completion pulse, VF result
module chip8_sprite_drawer #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        n,
  input  logic [ADDR_W-1:0] i_reg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              draw,
  output logic [5:0]        x,
  output logic [4:0]        y,
  output logic [3:0]        row_index,
  output logic [7:0]        sprite_data,
  input  logic              collision,
  output logic              busy,
  output logic              done,
  output logic [7:0]        vf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DRAW,
    S_COLL,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [5:0]          x_q, x_d;
  logic [4:0]          y_q, y_d;
  logic [3:0]          n_q, n_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [3:0]          row_q, row_d;
  logic [7:0]          data_q, data_d;
  logic                acc_q, acc_d;
  logic [7:0]          vf_q, vf_d;
  logic                acc_next;
  logic                last_row;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      base_q  <= '0;
      row_q   <= '0;
      data_q  <= '0;
      acc_q   <= 1'b0;
      vf_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      base_q  <= base_d;
      row_q   <= row_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      vf_q    <= vf_d;
    end
  end

  // COLL is the only state that consumes the collision input.
  assign acc_next = acc_q | collision;
  assign last_row = (row_q == (n_q - 4'd1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    base_d  = base_q;
    row_d   = row_q;
    data_d  = data_q;
    acc_d   = acc_q;
    vf_d    = vf_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d    = vx[5:0];
          y_d    = vy[4:0];
          n_d    = n;
          base_d = i_reg;
          row_d  = '0;
          acc_d  = 1'b0;
          if (n == 4'd0) begin
            // Empty sprite: result is known now, so
            // vf is valid alongside the done pulse.
            vf_d    = 8'h00;
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = mem_data;
        state_d = S_DRAW;
      end
      S_DRAW: state_d = S_COLL;
      S_COLL: begin
        acc_d = acc_next;
        if (last_row) begin
          // Load vf on entry to DONE so it is
          // already valid while done is high.
          vf_d    = {7'b0, acc_next};
          state_d = S_DONE;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode from state only, so reset
  // clears them asynchronously.
  assign mem_rd      = (state_q == S_FETCH);
  assign draw        = (state_q == S_DRAW);
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign mem_addr    = base_q + ADDR_W'(row_q);
  assign x           = x_q;
  assign y           = y_q;
  assign row_index   = row_q;
  assign sprite_data = data_q;
  assign vf          = vf_q;

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// tb_chip8_sprite_drawer: scoreboard bench for chip8_sprite_drawer.
// Stimulus pushes expected events; a negedge monitor pops and compares.
module tb_chip8_sprite_drawer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  vx = '0;
  logic [7:0]  vy = '0;
  logic [3:0]  n = '0;
  logic [11:0] i_reg = '0;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        draw;
  logic [5:0]  x;
  logic [4:0]  y;
  logic [3:0]  row_index;
  logic [7:0]  sprite_data;
  logic        collision;
  logic        busy;
  logic        done;
  logic [7:0]  vf;

  chip8_sprite_drawer #(.ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vx(vx), .vy(vy), .n(n), .i_reg(i_reg),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_data(mem_data), .draw(draw), .x(x),
    .y(y), .row_index(row_index),
    .sprite_data(sprite_data),
    .collision(collision), .busy(busy),
    .done(done), .vf(vf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory and display models.
  logic [7:0]  mem [4096];
  logic [15:0] mask = '0;
  logic        noise = 1'b0;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
    collision <= draw ? mask[row_index] : noise;
  end

  typedef struct {
    int         k;
    int         t;
    logic [11:0] a;
    logic [7:0]  d;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  r;
  } ev_t;

  localparam int K_RD   = 1;
  localparam int K_DRAW = 2;
  localparam int K_DONE = 3;

  ev_t q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic take(input int k,
                      output ev_t e,
                      output bit ok);
    ok = 1'b0;
    e = '{default: 0};
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected kind %0d at cyc %0d", k, cyc);
    end else begin
      e = q.pop_front();
      if (e.k != k) begin
        checks++;
        errors++;
        $display("FAIL order got kind %0d want %0d at cyc %0d",
                 k, e.k, cyc);
      end else begin
        ok = 1'b1;
      end
    end
  endtask

  bit         vf_pend = 1'b0;
  logic [7:0] vf_exp = '0;

  always @(negedge clk) begin
    ev_t e;
    bit ok;
    if (vf_pend) begin
      vf_pend = 1'b0;
      chk("vf_after_done", vf, vf_exp);
      chk("busy_after_done", busy, 1'b0);
    end
    if (mem_rd) begin
      take(K_RD, e, ok);
      if (ok) begin
        chk("rd_cyc", cyc, e.t);
        chk("rd_addr", mem_addr, e.a);
      end
    end
    if (draw) begin
      take(K_DRAW, e, ok);
      if (ok) begin
        chk("draw_cyc", cyc, e.t);
        chk("draw_x", x, e.x);
        chk("draw_y", y, e.y);
        chk("draw_row", row_index, e.r);
        chk("draw_data", sprite_data, e.d);
      end
    end
    if (done) begin
      take(K_DONE, e, ok);
      if (ok) begin
        chk("done_cyc", cyc, e.t);
        chk("busy_at_done", busy, 1'b1);
        vf_pend = 1'b1;
        vf_exp  = e.d;
      end
    end
  end

  // Issues start in the current cycle, pushes the expected
  // events, and returns in the cycle after done. A second
  // start is pulsed at offset poke (0 = none).
  task automatic run(input logic [7:0] ivx,
                     input logic [7:0] ivy,
                     input logic [3:0] in,
                     input logic [11:0] ib,
                     input logic [15:0] im,
                     input int poke);
    ev_t e;
    int c;
    int nn;
    logic [11:0] a;
    logic acc;
    nn = int'(in);
    vx = ivx;
    vy = ivy;
    n = in;
    i_reg = ib;
    mask = im;
    start = 1'b1;
    c = cyc;
    acc = 1'b0;
    e = '{default: 0};
    for (int r = 0; r < nn; r++) begin
      a = ib + 12'(r);
      e.k = K_RD;
      e.t = c + 1 + 4 * r;
      e.a = a;
      q.push_back(e);
      e.k = K_DRAW;
      e.t = c + 3 + 4 * r;
      e.d = mem[a];
      e.x = ivx[5:0];
      e.y = ivy[4:0];
      e.r = 4'(r);
      q.push_back(e);
      acc = acc | im[r];
    end
    e.k = K_DONE;
    e.t = c + 4 * nn + 1;
    e.d = {7'b0, acc};
    q.push_back(e);
    for (int k = 1; k <= 4 * nn + 2; k++) begin
      @(posedge clk);
      #1;
      start = (k == poke);
    end
    start = 1'b0;
  endtask

  initial begin
    ev_t e;
    int c;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'hF0;
    mem[12'h300] = 8'h80;
    mem[12'h301] = 8'h40;
    mem[12'h302] = 8'h20;
    mem[12'hFFF] = 8'hAA;
    mem[12'h000] = 8'h55;

    #1;
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_draw", draw, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", mem_addr, 12'h000);
    chk("rst_xy", {x, y}, 11'h000);
    chk("rst_row", row_index, 4'h0);
    chk("rst_data", sprite_data, 8'h00);
    chk("rst_vf", vf, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single row.
    run(8'd10, 8'd5, 4'd1, 12'h200, 16'h0000, 0);
    // Collision on row 1 only.
    run(8'd3, 8'd7, 4'd3, 12'h300, 16'h0002, 0);
    // n=0 clears vf; collision noise must be ignored.
    noise = 1'b1;
    run(8'd1, 8'd1, 4'd0, 12'h123, 16'h0000, 0);
    // Coordinate and address wrap.
    run(8'd70, 8'd40, 4'd2, 12'hFFF, 16'h0000, 0);
    noise = 1'b0;
    // Start while busy is ignored, then back-to-back start.
    run(8'd1, 8'd2, 4'd2, 12'h300, 16'h0000, 2);
    run(8'd0, 8'd31, 4'd1, 12'h300, 16'h0000, 0);
    // Set vf to 1 ahead of the reset test.
    run(8'd4, 8'd4, 4'd1, 12'h301, 16'h0001, 0);

    // Reset while in DRAW.
    vx = 8'd9;
    vy = 8'd9;
    n = 4'd2;
    i_reg = 12'h200;
    mask = 16'h0000;
    start = 1'b1;
    c = cyc;
    e = '{default: 0};
    e.k = K_RD;
    e.t = c + 1;
    e.a = 12'h200;
    q.push_back(e);
    e.k = K_DRAW;
    e.t = c + 3;
    e.d = mem[12'h200];
    e.x = 6'd9;
    e.y = 5'd9;
    e.r = 4'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #6;
    chk("pre_rst_draw", draw, 1'b1);
    chk("pre_rst_vf", vf, 8'h01);
    reset = 1'b1;
    #1;
    chk("mid_rst_draw", draw, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_vf", vf, 8'h00);
    chk("mid_rst_done", done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Normal run after reset.
    run(8'd10, 8'd5, 4'd1, 12'h200, 16'h0001, 0);

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
